// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: frame-level controller for the serial "0 11111 0" detector.
// The host hands over parallel words on a valid/ready handshake. Each word is
// shifted MSB-first into an 8-state Moore detector whose state carries across
// word boundaries within a frame. Matches are counted per frame, and a
// one-cycle done pulse closes each frame.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   start       begins a frame (sampled only while idle)
//   in_valid    in_data/in_last are valid
//   in_data     word to scan, bit WIDTH-1 shifted first
//   in_last     marks the final word of the frame
//   in_ready    controller can accept a word
//   ser_bit     bit currently presented to the detector
//   det_pulse   high for one cycle after the bit that completes a match
//   match_count matches in the current/last frame (saturating)
//   overflow    sticky, a match arrived while the counter was saturated
//   busy        frame in progress
//   done        one-cycle end-of-frame pulse
module seq_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             det_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] D_A = 3'd0;
  localparam logic [2:0] D_B = 3'd1;
  localparam logic [2:0] D_C = 3'd2;
  localparam logic [2:0] D_D = 3'd3;
  localparam logic [2:0] D_E = 3'd4;
  localparam logic [2:0] D_F = 3'd5;
  localparam logic [2:0] D_G = 3'd6;
  localparam logic [2:0] D_H = 3'd7;

  logic [1:0]       state;
  logic [2:0]       det;
  logic [2:0]       det_nxt;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]    bitcnt;
  logic             last_q;

  assign ser_bit  = sreg[WIDTH-1];
  assign in_ready = (state == S_WAIT);
  assign busy     = (state == S_WAIT) || (state == S_SHIFT);
  assign done     = (state == S_DONE);

  // Detector next state for the bit currently on ser_bit. Only applied while
  // shifting, so the detector holds across WAIT gaps between words.
  always_comb begin
    det_nxt = D_A;
    case (det)
      D_A: det_nxt = ser_bit ? D_A : D_B;
      D_B: det_nxt = ser_bit ? D_C : D_B;
      D_C: det_nxt = ser_bit ? D_D : D_B;
      D_D: det_nxt = ser_bit ? D_E : D_B;
      D_E: det_nxt = ser_bit ? D_F : D_B;
      D_F: det_nxt = ser_bit ? D_G : D_B;
      D_G: det_nxt = ser_bit ? D_A : D_H;
      D_H: det_nxt = ser_bit ? D_C : D_B;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      det         <= D_A;
      sreg        <= '0;
      bitcnt      <= '0;
      last_q      <= 1'b0;
      match_count <= '0;
      overflow    <= 1'b0;
      det_pulse   <= 1'b0;
    end else begin
      det_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            det         <= D_A;
            match_count <= '0;
            overflow    <= 1'b0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (in_valid) begin
            sreg   <= in_data;
            last_q <= in_last;
            bitcnt <= BW'(WIDTH - 1);
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          det    <= det_nxt;
          sreg   <= {sreg[WIDTH-2:0], 1'b0};
          bitcnt <= bitcnt - BW'(1);
          // Counting on entry into H (not on residence) keeps idle cycles
          // parked in H from being counted again.
          if (det_nxt == D_H) begin
            det_pulse <= 1'b1;
            if (&match_count) overflow <= 1'b1;
            else              match_count <= match_count + CNT_W'(1);
          end
          if (bitcnt == '0) state <= last_q ? S_DONE : S_WAIT;
        end
        S_DONE: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl. Two instances share the stimulus: one with
// the default 4-bit counter and one with a 2-bit counter for saturation.
module tb_seq_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;

  logic       in_ready4, ser4, det4, ovf4, busy4, done4;
  logic [3:0] cnt4;
  logic       in_ready2, ser2, det2, ovf2, busy2, done2;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;
  int p4 = 0;
  int p2 = 0;
  int d4 = 0;
  int pidx;

  seq_scan_ctrl #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready4),
    .ser_bit(ser4), .det_pulse(det4), .match_count(cnt4),
    .overflow(ovf4), .busy(busy4), .done(done4)
  );

  seq_scan_ctrl #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready2),
    .ser_bit(ser2), .det_pulse(det2), .match_count(cnt2),
    .overflow(ovf2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  // Pulse tallies sampled mid-cycle.
  always @(negedge clk) begin
    if (det4)  p4 = p4 + 1;
    if (det2)  p2 = p2 + 1;
    if (done4) d4 = d4 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ready", {31'd0, in_ready4}, 1);
    chk("start_busy", {31'd0, busy4}, 1);
    chk("start_cnt4", {28'd0, cnt4}, 0);
    chk("start_ovf4", {31'd0, ovf4}, 0);
    chk("start_cnt2", {30'd0, cnt2}, 0);
    chk("start_ovf2", {31'd0, ovf2}, 0);
    p4 = 0; p2 = 0; d4 = 0;
  endtask

  // Hands over one word after 'gap' idle cycles, then follows it bit by bit.
  // stray: hold start/in_valid high (with different data) while shifting.
  // abort_at: stop following after that shift edge (0 = whole word).
  // pi: index of the first shift edge after which det_pulse was seen, 0 if none.
  task automatic run_word(input logic [7:0] d, input logic l, input int gap,
                          input logic stray, input int abort_at, output int pi);
    int n;
    int lim;
    pi = 0;
    in_valid = 1'b0;
    repeat (gap) tick();
    n = 0;
    while (!in_ready4 && n < 20) begin
      tick();
      n++;
    end
    chk("wait_ready", {31'd0, in_ready4}, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    chk("shift_busy_ready", {30'd0, busy4, in_ready4}, 32'b10);
    in_valid = stray;
    start    = stray;
    if (stray) in_data = ~d;
    lim = (abort_at != 0) ? abort_at : 8;
    for (int i = 1; i <= lim; i++) begin
      chk("ser_bit", {31'd0, ser4}, {31'd0, d[8-i]});
      tick();
      if (det4 && pi == 0) pi = i;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (abort_at == 0) begin
      if (l) chk("done_pulse", {31'd0, done4}, 1);
      else   chk("back_to_wait", {31'd0, in_ready4}, 1);
    end
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_outputs", {22'd0, in_ready4, busy4, done4, det4, ovf4, cnt4, ser4}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_after_rst", {30'd0, busy4, in_ready4}, 0);

    // Single match, pulse after E7, done after E8
    start_frame();
    run_word(8'b0111_1100, 1'b1, 0, 1'b0, 0, pidx);
    chk("t1_pulse_idx", pidx, 7);
    chk("t1_busy_in_done", {31'd0, busy4}, 0);
    chk("t1_cnt", {28'd0, cnt4}, 1);
    chk("t1_ovf", {31'd0, ovf4}, 0);
    tick();
    chk("t1_done_once", d4, 1);
    chk("t1_idle", {30'd0, busy4, in_ready4}, 0);

    // Six ones: no match
    start_frame();
    run_word(8'b0111_1110, 1'b1, 0, 1'b0, 0, pidx);
    chk("t2_cnt", {28'd0, cnt4}, 0);
    tick();
    chk("t2_no_pulse", p4, 0);

    // Overlap across a word boundary with a 3-cycle gap
    start_frame();
    run_word(8'b0111_1101, 1'b0, 0, 1'b0, 0, pidx);
    chk("t3_pulse1_idx", pidx, 7);
    chk("t3_cnt_mid", {28'd0, cnt4}, 1);
    run_word(8'b1111_0000, 1'b1, 3, 1'b0, 0, pidx);
    chk("t3_pulse2_idx", pidx, 5);
    chk("t3_cnt", {28'd0, cnt4}, 2);
    tick();
    chk("t3_pulses", p4, 2);

    // Stray start/in_valid; detector parked in H across a gap
    start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_start_in_wait", {30'd0, busy4, in_ready4}, 32'b11);
    run_word(8'b0011_1110, 1'b0, 0, 1'b1, 0, pidx);
    chk("t4_pulse_idx", pidx, 8);
    chk("t4_cnt_mid", {28'd0, cnt4}, 1);
    run_word(8'b1111_1111, 1'b1, 3, 1'b0, 0, pidx);
    chk("t4_no_recount", {28'd0, cnt4}, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_start_in_done", {30'd0, busy4, in_ready4}, 0);
    in_valid = 1'b1;
    in_data  = 8'b0111_1100;
    in_last  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t4_valid_in_idle", {29'd0, busy4, in_ready4, done4}, 0);
    chk("t4_cnt_kept", {28'd0, cnt4}, 1);
    chk("t4_done_once", d4, 1);

    // Saturation of the 2-bit counter
    start_frame();
    for (int w = 0; w < 4; w++) run_word(8'b0111_1101, 1'b0, 0, 1'b0, 0, pidx);
    run_word(8'b1111_0000, 1'b1, 0, 1'b0, 0, pidx);
    chk("t5_cnt4", {28'd0, cnt4}, 5);
    chk("t5_ovf4", {31'd0, ovf4}, 0);
    chk("t5_cnt2_sat", {30'd0, cnt2}, 3);
    chk("t5_ovf2", {31'd0, ovf2}, 1);
    tick();
    chk("t5_pulses2", p2, 5);
    chk("t5_ovf2_held", {31'd0, ovf2}, 1);
    start_frame();

    // Reset mid-shift, then a clean frame
    run_word(8'b0111_1100, 1'b0, 0, 1'b0, 0, pidx);
    chk("t6_cnt_pre", {28'd0, cnt4}, 1);
    run_word(8'b0111_1100, 1'b0, 0, 1'b0, 3, pidx);
    rst = 1'b1;
    #1;
    chk("t6_async_rst", {28'd0, cnt4}, 0);
    tick();
    rst = 1'b0;
    chk("t6_rst_outputs", {25'd0, busy4, in_ready4, det4, cnt4}, 0);
    tick();
    chk("t6_still_idle", {30'd0, busy4, in_ready4}, 0);
    start_frame();
    run_word(8'b0111_1100, 1'b1, 0, 1'b0, 0, pidx);
    chk("t6_pulse_idx", pidx, 7);
    chk("t6_cnt", {28'd0, cnt4}, 1);
    tick();
    chk("t6_done_once", d4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Frame-level controller for the serial "0 11111 0" pattern detector used in the CA5 serial datapath.
- Accepts parallel words over a valid/ready handshake and serializes each word MSB-first into an embedded 8-state Moore detector.
- Detector state carries across word boundaries within a frame. Matches are counted per frame, and a one-cycle done pulse ends each frame.
- Sits between the word-oriented host side and the bit-serial detection logic.

Parameters:
- WIDTH, 8, bits per input word (>=2).
- CNT_W, 4, width of match counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begins a frame; sampled only in IDLE.
- in_valid  input  1  in_data/in_last valid.
- in_data  input  WIDTH  word to scan; bit WIDTH-1 is shifted first.
- in_last  input  1  marks the final word of the frame.
- in_ready  output  1  controller can accept a word.
- ser_bit  output  1  bit currently fed to the detector (observability).
- det_pulse  output  1  high one cycle after the bit that completes a match.
- match_count  output  CNT_W  matches in current/last frame.
- overflow  output  1  sticky; counter saturated during the frame.
- busy  output  1  frame in progress.
- done  output  1  one-cycle end-of-frame pulse.

Behaviour:
- Reset values: ctrl state IDLE; detector state A; shift register, bit counter, last flag, match_count, overflow, det_pulse, done = 0; in_ready = 0; busy = 0.
- Control FSM states: IDLE, WAIT, SHIFT, DONE.
  - IDLE: in_ready=0, busy=0. On start=1: clear detector to A, match_count=0, overflow=0, go to WAIT. match_count/overflow keep the previous frame's values until start.
  - WAIT: in_ready=1, busy=1. On in_valid=1 (handshake edge): load in_data into the shift register, latch in_last, bitcnt=WIDTH-1, go to SHIFT. Otherwise hold; detector state holds.
  - SHIFT: in_ready=0, busy=1. Each cycle:
    - ser_bit = sreg[WIDTH-1]; shift_en=1.
    - Detector advances on ser_bit; sreg shifts left; bitcnt decrements.
    - When bitcnt==0: go to DONE if the latched last flag is set, else go to WAIT.
  - DONE: busy=0, done=1 for exactly one cycle, then IDLE. Any start seen during DONE is ignored.
- Detector (A..H, advances only when shift_en=1):
  - A: 0->B, 1->A.
  - B: 0->B, 1->C.
  - C: 0->B, 1->D.
  - D: 0->B, 1->E.
  - E: 0->B, 1->F.
  - F: 0->B, 1->G.
  - G: 0->H, 1->A.
  - H: 0->B, 1->C.
  - Matching is overlapping: a match's terminating 0 can open the next match.
  - Six or more consecutive ones do not match.
- Match counting:
  - On the shift edge where the detector next state is H, match_count increments and det_pulse is registered high for the following cycle only.
  - Idle cycles spent in H (e.g. waiting in WAIT) do not re-count.
- Saturation: at all-ones, match_count holds and overflow sets; overflow stays set until the next accepted start.
- Latency: with the handshake at edge E0, bit i (i=1..WIDTH) is shifted at edge Ei. For the last word, done is high in the cycle after E_WIDTH and match_count is final at that point.
- in_valid outside WAIT is ignored; no data is consumed. start outside IDLE is ignored.
- rst at any time, including mid-SHIFT, returns all state to reset values immediately; the partial frame is discarded.

Test Plan:
- WIDTH=8: start, then one word 8'b0111_1100 with last=1 -> det_pulse high in the cycle after E7, done in the cycle after E8, match_count=1, overflow=0.
- One word 8'b0111_1110 with last=1 (six ones) -> match_count=0, det_pulse never asserts.
- Overlap: words 8'b0111_1101, 8'b1111_0xxx (xxx=000), last on the 2nd word -> 2 matches; the second spans the word boundary; in_valid held low for 3 cycles between words causes no double count.
- CNT_W=2: frame of 4 words 8'b0111_1101 repeated plus 8'b1111_0000 -> match_count saturates at 3 and overflow=1. A subsequent start clears both to 0.
- Assert rst for one cycle midway through SHIFT -> busy, in_ready, match_count, det_pulse all 0 next cycle; state IDLE; a following start plus a clean word counts correctly.
- start pulsed in WAIT/SHIFT/DONE and in_valid pulsed in IDLE -> no state change, no word consumed, done still pulses exactly once per frame.
